taylor_input_dispatcher: RTL and testbench

- Feeds input samples to the array of Taylor-network cores from one upstream sample stream.
- Buffers incoming 19-bit signed samples in a small FIFO.
- Arbitrates the cores' 4-bit request codes round-robin, then drives the shared io_in bus with a one-hot grant so that exactly one core consumes each sample.
- Sits between the acquisition front end and the multicore array. It is the serving end of the cores' req_in interface.

---
 rtl/taylor_input_dispatcher.sv | 188 ++++++++++++++++++
 tb/tb_taylor_input_dispatcher.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/taylor_input_dispatcher.sv
// Purpose : buffers upstream signed samples and hands each one to exactly one requesting Taylor core, picked round-robin.
// Latency : grant/io_in follow an eligible request (with a non-empty FIFO) by 1 cycle; at most one grant every 2 cycles.
// Backpressure: s_ready drops while the sample FIFO is full or in reset; requests wait in IDLE while the FIFO is empty.

// Small synchronous FIFO holding samples until a core is granted.
module tid_sample_fifo #(
    parameter int DW    = 19,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DW-1:0]              wdata,
    output logic [DW-1:0]              rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (level == '0);
endmodule

// Purpose : round-robin dispatcher of FIFO'd samples onto the shared core io_in bus.
// Latency : grant registered one cycle after the winning request is seen in IDLE.
// Backpressure: s_ready = !full (and low during reset); a served core is masked until it drops its request.
module taylor_input_dispatcher #(
    parameter int          NCORES   = 23,
    parameter int          DEPTH    = 8,
    parameter logic [3:0]  REQ_CODE = 4'd1,
    parameter int          DW       = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [4*NCORES-1:0]        req_in,
    output logic [DW-1:0]              io_in,
    output logic [NCORES-1:0]          grant,
    output logic [15:0]                dispatch_cnt,
    output logic [$clog2(DEPTH):0]     fifo_level
);
    localparam int PW = $clog2(NCORES);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     win_q;
    logic [PW-1:0]     win_idx;
    logic              win_found;
    logic [NCORES-1:0] mask_q, mask_d;
    logic [NCORES-1:0] req_hit;
    logic [NCORES-1:0] eligible;
    logic [DW-1:0]     fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              take;

    assign s_ready = !rst && !fifo_full;
    assign push    = s_valid && s_ready;
    assign pop     = (state_q == GRANT);

    tid_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (s_data),
        .rdata (fifo_head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode request codes; anything other than REQ_CODE is treated as no request.
    always_comb begin
        req_hit  = '0;
        eligible = '0;
        for (int k = 0; k < NCORES; k++) begin
            req_hit[k]  = (req_in[4*k +: 4] == REQ_CODE);
            eligible[k] = req_hit[k] && !mask_q[k];
        end
    end

    // Round-robin search: first eligible core at or after the pointer, wrapping at NCORES.
    always_comb begin
        int idx;
        idx       = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NCORES) idx = idx - NCORES;
            if (!win_found && eligible[idx[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx[PW-1:0];
            end
        end
    end

    assign take = (state_q == IDLE) && !fifo_empty && win_found;

    // Next-state logic: GRANT lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (take) state_d = GRANT;
            GRANT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant, bus data and winner capture; io_in holds its last value between grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            io_in <= '0;
            win_q <= '0;
        end else if (take) begin
            grant <= {{(NCORES-1){1'b0}}, 1'b1} << win_idx;
            io_in <= fifo_head;
            win_q <= win_idx;
        end else begin
            grant <= '0;
        end
    end

    // Served core is masked; a mask bit clears as soon as that core stops requesting.
    always_comb begin
        mask_d = mask_q;
        if (pop) mask_d[win_q] = 1'b1;
        mask_d = mask_d & req_hit;
    end

    // Pointer, mask and dispatch counter advance on the grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            mask_q       <= '0;
            dispatch_cnt <= '0;
        end else begin
            mask_q <= mask_d;
            if (pop) begin
                dispatch_cnt <= dispatch_cnt + 16'd1;
                ptr_q        <= (win_q == PW'(NCORES-1)) ? '0 : win_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_taylor_input_dispatcher.sv
// Purpose : directed-vector bench for taylor_input_dispatcher with a grant scoreboard.
// Latency : expected grants are queued by stimulus and popped by the monitor when grant is non-zero.
// Backpressure: FIFO-full and empty-FIFO request cases are driven explicitly.
module tb_taylor_input_dispatcher;
    localparam int NC = 23;
    localparam int DP = 8;
    localparam int DW = 19;
    localparam int LW = $clog2(DP) + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic [4*NC-1:0]      req_in;
    logic [DW-1:0]        io_in;
    logic [NC-1:0]        grant;
    logic [15:0]          dispatch_cnt;
    logic [LW-1:0]        fifo_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NC-1:0]        g;
        logic signed [DW-1:0] d;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    taylor_input_dispatcher #(
        .NCORES(NC), .DEPTH(DP), .REQ_CODE(4'd1), .DW(DW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .req_in       (req_in),
        .io_in        (io_in),
        .grant        (grant),
        .dispatch_cnt (dispatch_cnt),
        .fifo_level   (fifo_level)
    );

    // Monitor: every non-zero grant must match the next queued expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (grant != '0) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_grant got grant=%h io=%0d expected no grant", grant, $signed(io_in));
            end else begin
                e = sb.pop_front();
                if (grant !== e.g || io_in !== e.d) begin
                    errors++;
                    $display("FAIL grant_seq got grant=%h io=%0d expected grant=%h io=%0d",
                             grant, $signed(io_in), e.g, e.d);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_req(input int k, input logic [3:0] code);
        req_in[4*k +: 4] = code;
    endtask

    task automatic expect_grant(input int k, input logic signed [DW-1:0] d);
        exp_t e;
        e.g    = '0;
        e.g[k] = 1'b1;
        e.d    = d;
        sb.push_back(e);
    endtask

    task automatic push_sample(input logic signed [DW-1:0] d);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic reset_pulse;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d grants outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        req_in  = '0;

        // Reset state
        tick();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_grant", grant, 0);
        chk("rst_io_in", io_in, 0);
        chk("rst_cnt", dispatch_cnt, 0);
        chk("rst_level", fifo_level, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_s_ready", s_ready, 1);

        // Buffering without requests
        push_sample(19'sd100);
        push_sample(-19'sd5);
        push_sample(19'sd262143);
        chk("t1_level", fifo_level, 3);
        chk("t1_grant", grant, 0);
        chk("t1_io_in", io_in, 0);
        chk("t1_s_ready", s_ready, 1);

        // Single core, held request served once
        reset_pulse();
        push_sample(19'sd100);
        chk("t2_level_pre", fifo_level, 1);
        expect_grant(3, 19'sd100);
        set_req(3, 4'd1);
        tick();
        chk("t2_grant", grant, 64'h8);
        chk("t2_io_in", longint'($signed(io_in)), 100);
        tick();
        chk("t2_cnt", dispatch_cnt, 1);
        chk("t2_level", fifo_level, 0);
        push_sample(19'sd55);
        repeat (6) tick();
        chk("t2_held_level", fifo_level, 1);
        chk("t2_held_cnt", dispatch_cnt, 1);
        expect_grant(3, 19'sd55);
        set_req(3, 4'd0);
        tick();
        set_req(3, 4'd1);
        repeat (3) tick();
        chk("t2_rearm_cnt", dispatch_cnt, 2);
        chk("t2_rearm_level", fifo_level, 0);
        set_req(3, 4'd0);
        tick();

        // Full FIFO backpressure
        for (int i = 0; i < 8; i++) push_sample(19'(200 + i));
        chk("t4_s_ready_full", s_ready, 0);
        chk("t4_level_full", fifo_level, 8);
        s_data  = 19'sd999;
        s_valid = 1'b1;
        tick();
        tick();
        s_valid = 1'b0;
        chk("t4_level_no_ninth", fifo_level, 8);
        expect_grant(7, 19'sd200);
        set_req(7, 4'd1);
        tick();
        chk("t4_grant", grant, 64'h80);
        tick();
        chk("t4_level_after", fifo_level, 7);
        chk("t4_s_ready_after", s_ready, 1);
        for (int i = 1; i < 8; i++) begin
            expect_grant(7, 19'(200 + i));
            set_req(7, 4'd0);
            tick();
            set_req(7, 4'd1);
            tick();
            tick();
        end
        set_req(7, 4'd0);
        wait_drain("t4_drain", 20);
        chk("t4_level_empty", fifo_level, 0);
        chk("t4_cnt", dispatch_cnt, 10);

        // Request pending on an empty FIFO
        set_req(1, 4'd1);
        repeat (10) tick();
        chk("t5_no_grant", grant, 0);
        chk("t5_cnt_hold", dispatch_cnt, 10);
        expect_grant(1, -19'sd262144);
        push_sample(-19'sd262144);
        chk("t5_grant_early", grant, 0);
        chk("t5_level", fifo_level, 1);
        tick();
        chk("t5_grant", grant, 64'h2);
        chk("t5_io_in", longint'($signed(io_in)), -262144);
        tick();
        chk("t5_cnt", dispatch_cnt, 11);
        set_req(1, 4'd0);
        tick();

        // Reset during a grant cycle
        for (int i = 0; i < 4; i++) push_sample(19'(300 + i));
        expect_grant(2, 19'sd300);
        set_req(2, 4'd1);
        tick();
        chk("t6_grant_cycle", grant, 64'h4);
        rst = 1'b1;
        tick();
        chk("t6_level", fifo_level, 0);
        chk("t6_grant", grant, 0);
        chk("t6_cnt", dispatch_cnt, 0);
        chk("t6_s_ready_in_rst", s_ready, 0);
        rst = 1'b0;
        tick();
        chk("t6_s_ready", s_ready, 1);
        expect_grant(2, 19'sd350);
        push_sample(19'sd350);
        wait_drain("t6_mask_cleared", 10);
        chk("t6_cnt_after", dispatch_cnt, 1);
        set_req(2, 4'd0);
        reset_pulse();

        // Round-robin order with wrap, ignored code on core 1
        for (int i = 0; i < 6; i++) push_sample(19'(11 + i));
        set_req(1, 4'h2);
        expect_grant(0, 19'sd11);
        expect_grant(5, 19'sd12);
        expect_grant(22, 19'sd13);
        set_req(0, 4'd1);
        set_req(5, 4'd1);
        set_req(22, 4'd1);
        repeat (7) tick();
        chk("t3_cnt_round1", dispatch_cnt, 3);
        set_req(0, 4'd0);
        set_req(5, 4'd0);
        set_req(22, 4'd0);
        tick();
        expect_grant(0, 19'sd14);
        expect_grant(5, 19'sd15);
        expect_grant(22, 19'sd16);
        set_req(0, 4'd1);
        set_req(5, 4'd1);
        set_req(22, 4'd1);
        wait_drain("t3_drain", 20);
        tick();
        chk("t3_cnt", dispatch_cnt, 6);
        chk("t3_level", fifo_level, 0);
        req_in = '0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
